// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Issue/hazard controller beside decode2. Tracks in-flight
//            register writes per register, serialises jumps (stall until
//            resolved, flush and redirect on taken), and sequences halt
//            (drain the scoreboard, then assert a sticky halt).
// Options  : HAZARD_WB_BYPASS_EN - when defined, a source operand whose
//            only pending write commits this cycle does not stall; the
//            register file writes through to the reader.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NREGS   = 16,
    parameter int MAXPEND = 3,
    parameter int PCW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     d_valid,
    input  logic [$clog2(NREGS)-1:0] d_rs0,
    input  logic                     d_rs0_used,
    input  logic [$clog2(NREGS)-1:0] d_rs1,
    input  logic                     d_rs1_used,
    input  logic [$clog2(NREGS)-1:0] d_rd,
    input  logic                     d_wen,
    input  logic                     d_is_jump,
    input  logic                     d_is_halt,
    input  logic                     wb_valid,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic                     br_resolve,
    input  logic                     br_taken,
    input  logic [PCW-1:0]           br_target,
    output logic                     stall,
    output logic                     issue,
    output logic                     flush,
    output logic                     pc_load,
    output logic [PCW-1:0]           pc_next,
    output logic                     halt,
    output logic [NREGS-1:0]         busy
);

    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(MAXPEND + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count     [NREGS];
    logic [CW-1:0] count_nxt [NREGS];
    logic          next_zero;

    logic rs0_pending;
    logic rs1_pending;
    logic rs0_bypass;
    logic rs1_bypass;
    logic rd_saturated;
    logic hazard;

    assign rs0_pending  = (count[d_rs0] != '0);
    assign rs1_pending  = (count[d_rs1] != '0);
    assign rd_saturated = (count[d_rd] == CW'(MAXPEND));

`ifdef HAZARD_WB_BYPASS_EN
    // The last outstanding write to a source retires this cycle; the register
    // file forwards it, so the reader need not wait.
    assign rs0_bypass = (count[d_rs0] == CW'(1)) & wb_valid & (wb_rd == d_rs0);
    assign rs1_bypass = (count[d_rs1] == CW'(1)) & wb_valid & (wb_rd == d_rs1);
`else
    assign rs0_bypass = 1'b0;
    assign rs1_bypass = 1'b0;
`endif

    // Saturation stall keeps the per-register counter from wrapping.
    assign hazard = (d_rs0_used & rs0_pending & ~rs0_bypass)
                  | (d_rs1_used & rs1_pending & ~rs1_bypass)
                  | (d_wen & rd_saturated);

    assign stall = (state != RUN) | flush | (d_valid & hazard);
    assign issue = d_valid & ~stall;

    // Next scoreboard counts: +1 on issuing writer, -1 on commit (never below 0).
    always_comb begin
        next_zero = 1'b1;
        for (int r = 0; r < NREGS; r++) begin
            count_nxt[r] = count[r];
            if ((issue & d_wen & (d_rd == RW'(r))) &&
                !(wb_valid & (wb_rd == RW'(r)) & (count[r] != '0))) begin
                count_nxt[r] = count[r] + CW'(1);
            end else if (!(issue & d_wen & (d_rd == RW'(r))) &&
                         (wb_valid & (wb_rd == RW'(r)) & (count[r] != '0))) begin
                count_nxt[r] = count[r] - CW'(1);
            end
            if (count_nxt[r] != '0) begin
                next_zero = 1'b0;
            end
        end
    end

    // Per-register busy flags exported to the rest of the pipeline.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (count[r] != '0);
        end
    end

    // Scoreboard registers; reset clears every pending write.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (!rst_n) begin
                count[r] <= '0;
            end else begin
                count[r] <= count_nxt[r];
            end
        end
    end

    // Control FSM with registered flush/redirect pulse and sticky halt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            flush   <= 1'b0;
            pc_load <= 1'b0;
            pc_next <= '0;
            halt    <= 1'b0;
        end else begin
            flush   <= 1'b0;
            pc_load <= 1'b0;
            case (state)
                RUN: begin
                    // Halt takes priority when an instruction carries both flags.
                    if (issue & d_is_halt) begin
                        state <= DRAIN;
                    end else if (issue & d_is_jump) begin
                        state <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (br_resolve) begin
                        state <= RUN;
                        if (br_taken) begin
                            flush   <= 1'b1;
                            pc_load <= 1'b1;
                            pc_next <= br_target;
                        end
                    end
                end
                DRAIN: begin
                    // Includes any commit landing this cycle.
                    if (next_zero) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end
                end
                HALTED: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Table-driven self-checking bench for hazard_ctrl. Each row sets
//            one cycle of inputs and the outputs expected in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        d_valid;
    logic [3:0]  d_rs0;
    logic        d_rs0_used;
    logic [3:0]  d_rs1;
    logic        d_rs1_used;
    logic [3:0]  d_rd;
    logic        d_wen;
    logic        d_is_jump;
    logic        d_is_halt;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        br_resolve;
    logic        br_taken;
    logic [15:0] br_target;
    logic        stall;
    logic        issue;
    logic        flush;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        halt;
    logic [15:0] busy;

    hazard_ctrl #(.NREGS(16), .MAXPEND(3), .PCW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_valid    (d_valid),
        .d_rs0      (d_rs0),
        .d_rs0_used (d_rs0_used),
        .d_rs1      (d_rs1),
        .d_rs1_used (d_rs1_used),
        .d_rd       (d_rd),
        .d_wen      (d_wen),
        .d_is_jump  (d_is_jump),
        .d_is_halt  (d_is_halt),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .stall      (stall),
        .issue      (issue),
        .flush      (flush),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .halt       (halt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, dv;
        logic [3:0]  rs0;  logic u0;
        logic [3:0]  rs1;  logic u1;
        logic [3:0]  rd;   logic wen;
        logic        jmp, hlt, wbv;
        logic [3:0]  wbrd;
        logic        brr, brt;
        logic [15:0] tgt;
        logic        e_stall, e_issue, e_flush, e_pcl;
        logic [15:0] e_pcn;
        logic        e_halt;
        logic [15:0] e_busy;
    } vec_t;

    typedef struct {
        int          row;
        logic        stall, issue, flush, pcl;
        logic [15:0] pcn;
        logic        halt;
        logic [15:0] busy;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic rst_n_i, input logic dv,
        input logic [3:0] rs0, input logic u0, input logic [3:0] rs1, input logic u1,
        input logic [3:0] rd, input logic wen, input logic jmp, input logic hlt,
        input logic wbv, input logic [3:0] wbrd, input logic brr, input logic brt, input logic [15:0] tgt,
        input logic es, input logic ei, input logic ef, input logic ep, input logic [15:0] epn,
        input logic eh, input logic [15:0] eb);
        vec_t v;
        v.rst_n = rst_n_i; v.dv = dv; v.rs0 = rs0; v.u0 = u0; v.rs1 = rs1; v.u1 = u1;
        v.rd = rd; v.wen = wen; v.jmp = jmp; v.hlt = hlt; v.wbv = wbv; v.wbrd = wbrd;
        v.brr = brr; v.brt = brt; v.tgt = tgt;
        v.e_stall = es; v.e_issue = ei; v.e_flush = ef; v.e_pcl = ep; v.e_pcn = epn;
        v.e_halt = eh; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        // Test 1: write r3, dependent read, commit, release.
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 3,1, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0008));
        vecs.push_back(mk(1,1, 3,1, 0,0, 0,0, 0,0, 1,3, 0,0,16'h0,    !BYP,BYP,0,0,16'h0000,0,16'h0008));
        vecs.push_back(mk(1,1, 3,1, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0000));
        // Test 6: commit to idle r7, resolve while in RUN.
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 1,7, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,1,16'h1234, 0,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));
        // Test 2: saturate r5, saturation stall, coincident inc/dec, drain.
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 1,5, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 1,5, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 1,5, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0020));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 1,5, 0,0,16'h0, 0,0,0,0,16'h0000,0,16'h0020));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));
        // Test 3: taken jump with redirect, then not-taken jump.
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 1,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 1,1,16'h0040, 1,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    1,0,1,1,16'h0040,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0040,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 1,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0040,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,16'h0099, 1,0,0,0,16'h0040,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0040,0,16'h0000));
        // Test 4: halt with r2 pending, drain on commit, sticky halt.
        vecs.push_back(mk(1,1, 0,0, 0,0, 2,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0040,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,1, 0,0, 0,0,16'h0,    0,1,0,0,16'h0040,0,16'h0004));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0040,0,16'h0004));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 1,2, 0,0,16'h0,    1,0,0,0,16'h0040,0,16'h0004));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 1,1,16'h0055, 1,0,0,0,16'h0040,1,16'h0000));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0, 1,0,0,0,16'h0040,1,16'h0000));
        // Test 5: reset out of HALTED, then reset during DRAIN with r1/r2 pending.
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0040,1,16'h0000));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 1,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 0,0, 0,0, 2,1, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0002));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 1,1, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0006));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0006));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 1,1,16'h0077, 1,0,0,0,16'h0000,0,16'h0006));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0, 1,1, 0,0,16'h0,    1,0,0,0,16'h0000,0,16'h0006));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,1, 1,1, 2,1, 0,0, 0,0, 0,0, 0,0,16'h0,    0,1,0,0,16'h0000,0,16'h0000));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,16'h0,    0,0,0,0,16'h0000,0,16'h0000));

        rst_n = 1'b0; d_valid = 1'b0; d_rs0 = '0; d_rs0_used = 1'b0; d_rs1 = '0;
        d_rs1_used = 1'b0; d_rd = '0; d_wen = 1'b0; d_is_jump = 1'b0; d_is_halt = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; br_resolve = 1'b0; br_taken = 1'b0; br_target = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            exp_t g;
            @(posedge clk);
            #1;
            rst_n      = vecs[i].rst_n;
            d_valid    = vecs[i].dv;
            d_rs0      = vecs[i].rs0;
            d_rs0_used = vecs[i].u0;
            d_rs1      = vecs[i].rs1;
            d_rs1_used = vecs[i].u1;
            d_rd       = vecs[i].rd;
            d_wen      = vecs[i].wen;
            d_is_jump  = vecs[i].jmp;
            d_is_halt  = vecs[i].hlt;
            wb_valid   = vecs[i].wbv;
            wb_rd      = vecs[i].wbrd;
            br_resolve = vecs[i].brr;
            br_taken   = vecs[i].brt;
            br_target  = vecs[i].tgt;
            e.row   = i;
            e.stall = vecs[i].e_stall;
            e.issue = vecs[i].e_issue;
            e.flush = vecs[i].e_flush;
            e.pcl   = vecs[i].e_pcl;
            e.pcn   = vecs[i].e_pcn;
            e.halt  = vecs[i].e_halt;
            e.busy  = vecs[i].e_busy;
            expq.push_back(e);

            @(negedge clk);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard row %0d: got empty queue, expected entry", i);
            end else begin
                g = expq.pop_front();
                chk("stall",   g.row, {15'd0, stall},   {15'd0, g.stall});
                chk("issue",   g.row, {15'd0, issue},   {15'd0, g.issue});
                chk("flush",   g.row, {15'd0, flush},   {15'd0, g.flush});
                chk("pc_load", g.row, {15'd0, pc_load}, {15'd0, g.pcl});
                chk("pc_next", g.row, pc_next,          g.pcn);
                chk("halt",    g.row, {15'd0, halt},    {15'd0, g.halt});
                chk("busy",    g.row, busy,             g.busy);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
